// File: rtl/delay_requester.sv
// Initiator side of the PC-stall handshake: turns decode stall requests into
// delayEn edges, tracks the counter's pcEn ack/release and flags protocol errors.
module delay_requester #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ACK_TIMEOUT   = 4,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallReq,
  input  logic             pcEn,
  input  logic             clrErr,
  output logic             delayEn,
  output logic             stallActive,
  output logic             stallDone,
  output logic [CNT_W-1:0] stallLen,
  output logic [CNT_W-1:0] reqCount,
  output logic             pendingFull,
  output logic             overflow,
  output logic             timeout
);

  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned WAIT_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              pend_q, pend_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  len_cnt_q, len_cnt_d;
  logic [CNT_W-1:0]  stall_len_q, stall_len_d;
  logic [CNT_W-1:0]  req_count_q, req_count_d;
  logic              delay_en_q, delay_en_d;
  logic              stall_active_q, stall_active_d;
  logic              stall_done_q, stall_done_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic              ovf_set, to_set;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pend_q         <= 1'b0;
      ack_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      len_cnt_q      <= '0;
      stall_len_q    <= '0;
      req_count_q    <= '0;
      delay_en_q     <= 1'b0;
      stall_active_q <= 1'b0;
      stall_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      ack_cnt_q      <= ack_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      len_cnt_q      <= len_cnt_d;
      stall_len_q    <= stall_len_d;
      req_count_q    <= req_count_d;
      delay_en_q     <= delay_en_d;
      stall_active_q <= stall_active_d;
      stall_done_q   <= stall_done_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next-state, buffering and error logic
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    ack_cnt_d   = '0;
    wait_cnt_d  = '0;
    len_cnt_d   = len_cnt_q;
    stall_len_d = stall_len_q;
    req_count_d = req_count_q;
    ovf_set     = 1'b0;
    to_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stallReq || pend_q) begin
          state_d = S_REQ;
          // pending issued first; a simultaneous new request takes its slot
          pend_d  = stallReq && pend_q;
        end
      end
      S_REQ: begin
        if (stallReq) begin
          if (pend_q) ovf_set = 1'b1;
          else        pend_d  = 1'b1;
        end
        if (!pcEn) begin
          state_d   = S_WAIT;
          len_cnt_d = CNT_W'(1);
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d = S_IDLE;
          to_set  = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_WAIT: begin
        if (stallReq) begin
          if (pend_q) ovf_set = 1'b1;
          else        pend_d  = 1'b1;
        end
        if (pcEn) begin
          state_d     = S_DONE;
          stall_len_d = len_cnt_q;
          if (req_count_q != CNT_MAX) req_count_d = req_count_q + CNT_W'(1);
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          to_set  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (len_cnt_q != CNT_MAX) len_cnt_d = len_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (pend_q) begin
          state_d = S_REQ;
          pend_d  = stallReq;
        end else if (stallReq) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    overflow_d     = ovf_set || (overflow_q && !clrErr);
    timeout_d      = to_set  || (timeout_q  && !clrErr);
    delay_en_d     = (state_d == S_REQ);
    stall_active_d = (state_d == S_REQ) || (state_d == S_WAIT);
    stall_done_d   = (state_d == S_DONE);
  end

  assign delayEn     = delay_en_q;
  assign stallActive = stall_active_q;
  assign stallDone   = stall_done_q;
  assign stallLen    = stall_len_q;
  assign reqCount    = req_count_q;
  assign pendingFull = pend_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_delay_requester.sv
// Self-checking bench for delay_requester: reactive delay-counter model on pcEn,
// per-cycle reference model comparison, directed scenarios and random traffic.
module tb_delay_requester;

  localparam int CNT_MAX  = 255;
  localparam int ACK_TO   = 4;
  localparam int STALL_TO = 64;

  localparam int P_IDLE  = 0;
  localparam int P_ASK   = 1;
  localparam int P_STALL = 2;
  localparam int P_FIN   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stallReq = 1'b0;
  logic       pcEn = 1'b1;
  logic       clrErr = 1'b0;
  logic       delayEn, stallActive, stallDone, pendingFull, overflow, timeout;
  logic [7:0] stallLen, reqCount;

  int checks = 0;
  int failures = 0;

  // reference model
  int m_phase = P_IDLE;
  bit m_pend = 0, m_ovf = 0, m_to = 0;
  int m_asked = 0, m_wait = 0, m_len = 0, m_last = 0, m_done = 0;

  // DUT activity monitors
  int dl_hi = 0, done_pulses = 0, rises = 0, act_cnt = 0;
  bit prev_de = 0;
  int b_dl, b_done, b_rise, b_act;

  // delay counter model controls
  int cm_delay = 1, cm_len = 15;
  bit cm_rand = 0, cm_kill = 0;
  int cm_cnt = -1;

  always #5 clk = ~clk;

  delay_requester #(.CNT_W(8), .ACK_TIMEOUT(4), .STALL_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .stallReq(stallReq), .pcEn(pcEn), .clrErr(clrErr),
    .delayEn(delayEn), .stallActive(stallActive), .stallDone(stallDone),
    .stallLen(stallLen), .reqCount(reqCount), .pendingFull(pendingFull),
    .overflow(overflow), .timeout(timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic buffer_req(inout bit ovf_ev);
    if (stallReq) begin
      if (m_pend) ovf_ev = 1;
      else        m_pend = 1;
    end
  endtask

  // One clock of the request lifecycle, from the sampled inputs
  task automatic model_step();
    bit ovf_ev, to_ev;
    ovf_ev = 0;
    to_ev  = 0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_pend = 0; m_ovf = 0; m_to = 0;
      m_asked = 0; m_wait = 0; m_len = 0; m_last = 0; m_done = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (stallReq || m_pend) begin
        m_pend  = stallReq && m_pend;
        m_phase = P_ASK;
        m_asked = 0;
      end
      P_ASK: begin
        buffer_req(ovf_ev);
        if (!pcEn) begin
          m_phase = P_STALL; m_len = 1; m_wait = 0;
        end else begin
          m_asked++;
          if (m_asked >= ACK_TO) begin m_phase = P_IDLE; to_ev = 1; end
        end
      end
      P_STALL: begin
        buffer_req(ovf_ev);
        if (pcEn) begin
          m_phase = P_FIN;
          m_last  = m_len;
          if (m_done < CNT_MAX) m_done++;
        end else begin
          m_wait++;
          if (m_wait >= STALL_TO) begin m_phase = P_IDLE; to_ev = 1; end
          else if (m_len < CNT_MAX) m_len++;
        end
      end
      default: begin
        m_phase = (m_pend || stallReq) ? P_ASK : P_IDLE;
        m_asked = 0;
        if (m_pend) m_pend = stallReq;
      end
    endcase
    m_ovf = ovf_ev || (m_ovf && !clrErr);
    m_to  = to_ev  || (m_to  && !clrErr);
  endtask

  // Compare process: model vs DUT every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      chk("delayEn",     int'(delayEn),     int'(m_phase == P_ASK));
      chk("stallActive", int'(stallActive), int'(m_phase == P_ASK || m_phase == P_STALL));
      chk("stallDone",   int'(stallDone),   int'(m_phase == P_FIN));
      chk("stallLen",    int'(stallLen),    m_last);
      chk("reqCount",    int'(reqCount),    m_done);
      chk("pendingFull", int'(pendingFull), int'(m_pend));
      chk("overflow",    int'(overflow),    int'(m_ovf));
      chk("timeout",     int'(timeout),     int'(m_to));
      if (delayEn) dl_hi++;
      if (stallDone) done_pulses++;
      if (delayEn && !prev_de) rises++;
      if (stallActive) act_cnt++;
      prev_de = delayEn;
    end
  end

  // Delay counter model: after each delayEn rise, wait cur_d, then pull pcEn low cur_l cycles
  initial begin
    int cur_d, cur_l;
    bit seen;
    cur_d = 0; cur_l = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (cm_kill) begin
        cm_cnt = -1;
        pcEn   = 1'b1;
      end else begin
        if (delayEn && !seen) begin
          cm_cnt = 0;
          cur_d  = cm_rand ? int'($urandom_range(0, 2)) : cm_delay;
          cur_l  = cm_rand ? int'($urandom_range(0, 6)) : cm_len;
        end
        if (cm_cnt >= 0) begin
          cm_cnt++;
          pcEn = (cm_cnt > cur_d && cm_cnt <= cur_d + cur_l) ? 1'b0 : 1'b1;
          if (cm_cnt > cur_d + cur_l) cm_cnt = -1;
        end
      end
      seen = delayEn;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_dl = dl_hi; b_done = done_pulses; b_rise = rises; b_act = act_cnt;
  endtask

  task automatic pulse_req();
    stallReq = 1'b1;
    tick(1);
    stallReq = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stallReq = 1'b0; clrErr = 1'b0; cm_kill = 1'b1;
    tick(2);
    rst_n = 1'b1; cm_kill = 1'b0;
    tick(1);
    snap();
  endtask

  task automatic settle(input string name, input int budget);
    int n;
    n = 0;
    while (!(m_phase == P_IDLE && !m_pend && cm_cnt < 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, int'(n < budget), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_delayEn"},     int'(delayEn),     0);
    chk({tag, "_stallActive"}, int'(stallActive), 0);
    chk({tag, "_stallDone"},   int'(stallDone),   0);
    chk({tag, "_stallLen"},    int'(stallLen),    0);
    chk({tag, "_reqCount"},    int'(reqCount),    0);
    chk({tag, "_pendingFull"}, int'(pendingFull), 0);
    chk({tag, "_overflow"},    int'(overflow),    0);
    chk({tag, "_timeout"},     int'(timeout),     0);
  endtask

  initial begin
    int n;
    // reset state
    tick(2);
    chk_all_zero("reset");
    apply_reset();

    // single stall: pcEn low 15 cycles
    cm_delay = 1; cm_len = 15;
    pulse_req();
    settle("t1_settle", 100);
    chk("t1_delayEn_hi",  dl_hi - b_dl, 2);
    chk("t1_done_pulses", done_pulses - b_done, 1);
    chk("t1_stallLen",    int'(stallLen), 15);
    chk("t1_reqCount",    int'(reqCount), 1);
    chk("t1_model_len",   m_last, 15);

    // request buffered during WAIT
    apply_reset();
    pulse_req();
    tick(5);
    pulse_req();
    chk("t2_pending", int'(pendingFull), 1);
    settle("t2_settle", 200);
    chk("t2_rises",       rises - b_rise, 2);
    chk("t2_done_pulses", done_pulses - b_done, 2);
    chk("t2_reqCount",    int'(reqCount), 2);
    chk("t2_pending_end", int'(pendingFull), 0);

    // overflow, then clrErr
    apply_reset();
    pulse_req();
    tick(4);
    pulse_req();
    tick(2);
    pulse_req();
    chk("t3_overflow_set", int'(overflow), 1);
    chk("t3_pending",      int'(pendingFull), 1);
    settle("t3_settle", 200);
    chk("t3_reqCount", int'(reqCount), 2);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    chk("t3_overflow_clr", int'(overflow), 0);

    // ack timeout: counter never drops pcEn
    apply_reset();
    cm_len = 0;
    pulse_req();
    settle("t4_settle", 50);
    chk("t4_timeout",     int'(timeout), 1);
    chk("t4_delayEn_hi",  dl_hi - b_dl, 4);
    chk("t4_done_pulses", done_pulses - b_done, 0);
    chk("t4_reqCount",    int'(reqCount), 0);
    chk("t4_delayEn",     int'(delayEn), 0);

    // stall timeout: pcEn held low 100 cycles
    apply_reset();
    cm_delay = 1; cm_len = 100;
    pulse_req();
    settle("t5_settle", 200);
    chk("t5_timeout",     int'(timeout), 1);
    chk("t5_active_cyc",  act_cnt - b_act, 66);
    chk("t5_done_pulses", done_pulses - b_done, 0);
    cm_len = 3;
    pulse_req();
    settle("t5b_settle", 50);
    chk("t5_rises",       rises - b_rise, 2);
    chk("t5_done_after",  done_pulses - b_done, 1);
    chk("t5_stallLen",    int'(stallLen), 3);
    chk("t5_timeout_stk", int'(timeout), 1);

    // async reset mid-WAIT with pending set
    apply_reset();
    cm_delay = 1; cm_len = 20;
    pulse_req();
    tick(6);
    pulse_req();
    tick(3);
    chk("t6_pend_before", int'(pendingFull), 1);
    chk("t6_active_before", int'(stallActive), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick(2);
    rst_n = 1'b1;
    snap();
    tick(30);
    chk("t6_done_pulses", done_pulses - b_done, 0);
    chk("t6_rises",       rises - b_rise, 0);

    // random traffic against the model
    apply_reset();
    cm_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      stallReq = ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0;
      clrErr   = ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0;
      tick(1);
    end
    stallReq = 1'b0; clrErr = 1'b0; cm_rand = 1'b0;
    settle("t7_settle", 200);

    // reqCount saturation over 300 back-to-back stalls
    apply_reset();
    cm_delay = 0; cm_len = 1;
    stallReq = 1'b1;
    n = 0;
    while (done_pulses - b_done < 300 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("t8_bound", int'(n < 3000), 1);
    stallReq = 1'b0;
    settle("t8_settle", 100);
    chk("t8_reqCount", int'(reqCount), 255);
    chk("t8_stallLen", int'(stallLen), 1);
    chk("t8_overflow", int'(overflow), 1);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/delay_requester.md
Name: delay_requester

Overview:
- Initiator side of the PC-stall handshake. It converts single-cycle stall requests from decode into clean rising edges on delayEn for the delay counter.
- It tracks the counter's pcEn acknowledge/release, measures each stall length, buffers one pending request, and flags protocol errors (missing ack, stall overrun, request overflow).
- Sits between instruction decode and the delay counter in the pineapple core.

Parameters:
- CNT_W, 8, width of stallLen and reqCount (both saturate at 2**CNT_W-1)
- ACK_TIMEOUT, 4, max clocks in REQ without pcEn sampled low before error
- STALL_TIMEOUT, 64, max clocks in WAIT without pcEn sampled high before error

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stallReq  in  1  decode request; each cycle sampled high = one request
- pcEn  in  1  from delay counter; 0 = stall in progress, 1 = PC may advance
- clrErr  in  1  synchronous clear of overflow and timeout
- delayEn  out  1  to delay counter; each rising edge starts one stall
- stallActive  out  1  high while state is REQ or WAIT
- stallDone  out  1  one-cycle pulse on successful stall completion
- stallLen  out  CNT_W  pcEn-low cycle count of last completed stall
- reqCount  out  CNT_W  completed-stall count, saturating
- pendingFull  out  1  one request buffered behind the active one
- overflow  out  1  sticky: request dropped because buffer was full
- timeout  out  1  sticky: ACK_TIMEOUT or STALL_TIMEOUT expired

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0, including stallLen and reqCount; pending buffer empty; internal counters 0.
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE:
  - stallReq=1 or pending set -> REQ next cycle; a request consumed from pending clears pendingFull.
  - delayEn=0.
- REQ:
  - delayEn=1.
  - pcEn sampled 0 -> WAIT. This edge counts as the first pcEn-low cycle (lenCnt=1).
  - Else ackCnt++. If ackCnt reaches ACK_TIMEOUT -> IDLE, timeout=1, stallDone not asserted.
- WAIT:
  - delayEn=0, so the next request produces a fresh edge.
  - pcEn sampled 0 -> lenCnt++ (saturating).
  - pcEn sampled 1 -> DONE.
  - If WAIT duration reaches STALL_TIMEOUT -> IDLE, timeout=1, pending preserved.
- DONE (one cycle):
  - stallDone=1; stallLen<=lenCnt; reqCount++ (saturating); delayEn=0.
  - Next state: REQ if pending set or stallReq=1, else IDLE.
  - DONE guarantees delayEn low for at least 2 cycles between requests.
- Request buffering:
  - stallReq=1 while state is not IDLE, or in DONE when the DONE->REQ transition already uses pending: set pending if empty, else overflow=1 and the request is dropped.
  - stallReq in DONE with pending empty is consumed directly by the DONE->REQ transition.
  - stallReq in IDLE with pending set: the pending request is issued, and the new one is buffered.
- clrErr=1 clears overflow and timeout on the next edge. If an error event occurs in the same cycle, the set wins.
- Timeout does not clear stallLen or reqCount.
- An async reset mid-stall drops delayEn immediately and discards pending. The delay counter is not otherwise notified; its own pcEn release must be tolerated afterwards (pcEn=1 in IDLE is ignored).
- pcEn is ignored in IDLE and DONE.

Test Plan:
- Reset, then a single stallReq pulse; bench counter model drops pcEn 1 cycle after delayEn rises and holds it low 15 cycles -> delayEn high exactly 2 cycles, stallDone pulses once, stallLen=15, reqCount=1.
- stallReq pulsed during WAIT of the first stall -> pendingFull=1; after DONE, REQ is re-entered with delayEn low 2 cycles between rising edges; second stallDone; reqCount=2; pendingFull=0.
- Three stallReq pulses during one stall -> second is buffered, third sets overflow=1; reqCount ends at 2; clrErr then clears overflow.
- Model never drops pcEn -> after 4 cycles in REQ, timeout=1, state IDLE, delayEn=0, stallDone never asserted, reqCount unchanged.
- Model holds pcEn low 100 cycles -> timeout=1 after 64 WAIT cycles; next stallReq issues a new delayEn edge.
- rst_n asserted mid-WAIT with pending set -> all outputs 0 asynchronously; after release, pcEn activity produces no stallDone without a new stallReq.
- 300 back-to-back stalls with CNT_W=8 -> reqCount saturates at 255.
